// File: rtl/imm_decode_pkg.sv
// Shared types for the immediate-decode stage:
// format enum, opcode constants and the buffered entry layout.
package imm_decode_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SHAMT
    } imm_fmt_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        imm_fmt_t            fmt;
        logic                illegal;
    } dec_entry_t;

endpackage

// File: rtl/imm_decode_if.sv
// Fetch-side and consumer-side handshake bundle of the stage.
// The stage itself takes the slave view.
interface imm_decode_if
    import imm_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [DATA_WIDTH-1:0] in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [DATA_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_imm;
    imm_fmt_t              out_fmt;
    logic                  out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_decode_stage_imm_extract.sv
// Combinational immediate classifier and extender.
// Every format is first built as a 32-bit value, then sign-extended.
module imm_extract
    import imm_decode_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter bit UNSIGNED_ZEXT = 1'b0
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm,
    output imm_fmt_t              fmt,
    output logic                  illegal
);
    localparam bit RV64 = (DATA_WIDTH == 64);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        op_imm;
    logic        op_w;
    logic        shift;
    logic        i_type;
    logic        bad_f6;
    logic        sgn;
    logic [31:0] v32;

    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign op_imm = (opc == OP_IMM);
    assign op_w   = RV64 && (opc == OP_IMM_32);
    assign shift  = (op_imm || op_w) && (f3[1:0] == 2'b01);
    assign i_type = ((op_imm || op_w) && !shift)
                  || (opc == LOAD) || (opc == JALR);
    assign bad_f6 = (instr[31:26] != 6'b000000)
                 && (instr[31:26] != 6'b010000);

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        v32     = '0;
        sgn     = instr[31];
        unique case (1'b1)
            shift: begin
                fmt = FMT_SHAMT;
                if (RV64 && op_imm) v32 = {26'b0, instr[25:20]};
                else                v32 = {27'b0, instr[24:20]};
                illegal = bad_f6 || (!RV64 && instr[25]);
            end
            i_type: begin
                fmt = FMT_I;
                if (UNSIGNED_ZEXT
                    && ((op_imm && f3 == 3'b011)
                        || (opc == LOAD && f3[2])))
                    sgn = 1'b0;
                v32 = {{20{sgn}}, instr[31:20]};
            end
            (opc == STORE): begin
                fmt = FMT_S;
                v32 = {{20{sgn}}, instr[31:25], instr[11:7]};
            end
            (opc == BRANCH): begin
                fmt = FMT_B;
                if (UNSIGNED_ZEXT && f3[2:1] == 2'b11) sgn = 1'b0;
                v32 = {{19{sgn}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            end
            (opc == LUI) || (opc == AUIPC): begin
                fmt = FMT_U;
                v32 = {instr[31:12], 12'b0};
            end
            (opc == JAL): begin
                fmt = FMT_J;
                v32 = {{11{sgn}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
            end
            default: illegal = (instr[1:0] == 2'b11);
        endcase
    end

    // zero-extended forms already carry a clear bit 31 here
    assign imm = DATA_WIDTH'($signed(v32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer
// (main output register plus one skid register).
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter bit UNSIGNED_ZEXT = 1'b0
) (
    input logic         clk,
    input logic         reset,
    input logic         flush,
    imm_decode_if.slave bus
);
    logic [DATA_WIDTH-1:0] d_imm;
    imm_fmt_t              d_fmt;
    logic                  d_ill;
    dec_entry_t            dec;
    dec_entry_t            main_q;
    dec_entry_t            skid_q;
    logic                  main_v;
    logic                  skid_v;
    logic                  take_in;
    logic                  load_main;

    imm_extract #(
        .DATA_WIDTH   (DATA_WIDTH),
        .UNSIGNED_ZEXT(UNSIGNED_ZEXT)
    ) u_ext (
        .instr  (bus.in_instr),
        .imm    (d_imm),
        .fmt    (d_fmt),
        .illegal(d_ill)
    );

    assign dec = '{
        instr:   bus.in_instr,
        pc:      XLEN_MAX'(bus.in_pc),
        imm:     XLEN_MAX'(d_imm),
        fmt:     d_fmt,
        illegal: d_ill
    };

    assign take_in   = bus.in_valid && !skid_v;
    assign load_main = !main_v || bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (load_main) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                main_v <= take_in;
                if (take_in) main_q <= dec;
            end
        end else if (take_in) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign bus.in_ready    = !skid_v;
    assign bus.out_valid   = main_v;
    assign bus.out_instr   = main_q.instr;
    assign bus.out_pc      = main_q.pc[DATA_WIDTH-1:0];
    assign bus.out_imm     = main_q.imm[DATA_WIDTH-1:0];
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;

    if (DATA_WIDTH < XLEN_MAX) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^{main_q.pc[XLEN_MAX-1:DATA_WIDTH],
                             main_q.imm[XLEN_MAX-1:DATA_WIDTH]};
    end

endmodule
